frame_ram_ctrl: RTL and testbench
=================================

FRAME_RAM_CTRL -- requirements
Module: frame_ram_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 480, number of frame rows (RAM depth).
REQ-002 SHALL have parameter COLS, default 640, pixels per row (RAM word width).
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports save_req input 1, save_addr input 9, save_data input COLS: request to OR a pixel mask into row save_addr.
REQ-006 SHALL have port save_ack  output  1  one-cycle pulse when the save write is committed.
REQ-007 SHALL have ports load_req input 1, load_addr input 9: request to read row load_addr.
REQ-008 SHALL have ports load_valid output 1, load_data output COLS: registered readback row, valid for one cycle.
REQ-009 SHALL have ports clear_start input 1, clear_busy output 1: whole-frame clear trigger and status.
REQ-010 SHALL have ports ram_addr output 9, ram_we output 1, ram_wdata output COLS, ram_rdata input COLS: single-port RAM, read latency 1 (address in cycle N, data valid in N+1).

Function
REQ-011 SHALL implement FSM states IDLE, S_RD, S_WR, L_RD, L_CAP, CLR.
REQ-012 SHALL arbitrate in IDLE with fixed priority clear_start > save_req > load_req; unselected requests stay pending (not acked, not dropped) while held high.
REQ-013 SHALL on save accepted at cycle T: T+1 S_RD (ram_addr=latched save_addr, ram_we=0); T+2 S_WR (ram_we=1, ram_wdata=ram_rdata | latched save_data, save_ack=1); T+3 IDLE.
REQ-014 SHALL on load accepted at cycle T: T+1 L_RD (ram_addr=latched load_addr); T+2 L_CAP capture ram_rdata into load_data; T+3 load_valid=1 for exactly one cycle, FSM in IDLE and able to accept a new request the same cycle.
REQ-015 SHALL latch save_addr/save_data/load_addr on acceptance; later input changes do not affect the in-flight operation.
REQ-016 SHALL, for save_addr >= ROWS, skip RAM access (ram_we stays 0) but still pulse save_ack at T+2.
REQ-017 SHALL, for load_addr >= ROWS, return load_data all zeros with load_valid at T+3.
REQ-018 SHALL in CLR write zero to rows 0..ROWS-1, one row per cycle, ascending, ram_we=1; clear_busy=1 throughout CLR; return to IDLE after row ROWS-1 (ROWS cycles total).
REQ-019 SHALL ignore clear_start while not in IDLE, including during CLR; a still-high clear_start on return to IDLE starts a new clear.
REQ-020 SHALL drive ram_we=0 in every state except S_WR (valid address) and CLR.
REQ-021 SHALL hold load_data between valid pulses; load_valid and save_ack never high in the same cycle as each other.

Reset
REQ-022 SHALL on reset_n low, immediately and asynchronously: state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, save_ack=0, load_valid=0, load_data=0, clear_busy=0, clear row counter=0.
REQ-023 SHALL abort any in-flight save, load or clear on reset without completing it; partially cleared frame is left as-is.

Configuration
REQ-024 SHALL compile the clear engine only when FRAME_CLEAR_EN is defined.
REQ-025 SHALL, without FRAME_CLEAR_EN, omit state CLR and row counter, ignore clear_start, tie clear_busy to 0; save/load behaviour unchanged.

Structure
REQ-026 SHALL place ROWS/COLS defaults, the 9-bit row address typedef and the FSM state enum in shared package paint_pkg.
REQ-027 SHALL be a single module; no sub-module required (clear row counter inline).

Verification
REQ-028 Save: RAM row 5 preloaded 0x0F, save_req addr 5 data 1<<10 -> ram_we pulse at T+2, row 5 = 0x40F, save_ack pulse at T+2.
REQ-029 Load: row 7 = 0xABCD, load_req addr 7 at T -> load_valid at T+3 only, load_data = 0xABCD.
REQ-030 Contention: save_req and load_req both high at T -> save completes first (ack T+2), load accepted T+3, load_valid T+6.
REQ-031 Clear: clear_start with save_req pending -> clear_busy high 480 cycles, rows 0..479 zero, then save serviced; with FRAME_CLEAR_EN undefined clear_busy stays 0, RAM untouched.
REQ-032 Out of range: save addr 500 -> ack, no ram_we; load addr 480 -> load_data 0.
REQ-033 Reset mid-clear at row 100 -> ram_we drops immediately, state IDLE, rows 100..479 retain prior contents.

Source files
------------

// File: rtl/paint_pkg.sv
// paint_pkg -- shared definitions for the frame RAM controller.
//   ROWS_DEF / COLS_DEF : default frame geometry (rows = RAM depth,
//                         cols = pixels per row = RAM word width)
//   row_addr_t          : 9-bit row address
//   state_e             : controller FSM states
// Optional feature macro: FRAME_CLEAR_EN (adds the CLR state).
package paint_pkg;

   localparam int unsigned ROWS_DEF = 480;
   localparam int unsigned COLS_DEF = 640;

   typedef logic [8:0] row_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      S_RD,
      S_WR,
      L_RD,
`ifdef FRAME_CLEAR_EN
      L_CAP,
      CLR
`else
      L_CAP
`endif
   } state_e;

endpackage

// File: rtl/frame_ram_ctrl.sv
// frame_ram_ctrl -- row-oriented controller in front of a single-port frame
// RAM (read latency 1). Services read-modify-write pixel saves, row loads and
// (optionally) a whole-frame clear, arbitrated clear > save > load.
//
// Ports:
//   CLOCK_50, reset_n            clock, asynchronous active-low reset
//   save_req/save_addr/save_data OR save_data into row save_addr
//   save_ack                     one-cycle pulse when the save write commits
//   load_req/load_addr           read row load_addr
//   load_valid/load_data         registered readback, valid for one cycle
//   clear_start/clear_busy       whole-frame clear trigger / status
//   ram_addr/ram_we/ram_wdata    RAM command outputs
//   ram_rdata                    RAM read data (valid the cycle after address)
//
// Optional feature macro: FRAME_CLEAR_EN -- when undefined the clear engine is
// not built, clear_start is ignored and clear_busy is tied low.
module frame_ram_ctrl
   import paint_pkg::*;
#(
   parameter int unsigned ROWS = ROWS_DEF,
   parameter int unsigned COLS = COLS_DEF
) (
   input  logic            CLOCK_50,
   input  logic            reset_n,
   input  logic            save_req,
   input  logic [8:0]      save_addr,
   input  logic [COLS-1:0] save_data,
   output logic            save_ack,
   input  logic            load_req,
   input  logic [8:0]      load_addr,
   output logic            load_valid,
   output logic [COLS-1:0] load_data,
   input  logic            clear_start,
   output logic            clear_busy,
   output logic [8:0]      ram_addr,
   output logic            ram_we,
   output logic [COLS-1:0] ram_wdata,
   input  logic [COLS-1:0] ram_rdata
);

   state_e          state_q, state_d;
   row_addr_t       save_addr_q, save_addr_d;
   logic [COLS-1:0] save_data_q, save_data_d;
   row_addr_t       load_addr_q, load_addr_d;
   logic [COLS-1:0] load_data_q, load_data_d;
   logic            load_valid_q, load_valid_d;
   logic            save_ack_q, save_ack_d;

   logic save_in_range;
   logic load_in_range;

   assign save_in_range = (32'(save_addr_q) < ROWS);
   assign load_in_range = (32'(load_addr_q) < ROWS);

`ifdef FRAME_CLEAR_EN
   row_addr_t clr_row_q, clr_row_d;
   logic      clr_last;

   assign clr_last   = (32'(clr_row_q) == (ROWS - 1));
   assign clear_busy = (state_q == CLR);
`else
   logic unused_clear_start;

   assign unused_clear_start = clear_start;
   assign clear_busy         = 1'b0;
`endif

   // RAM command outputs are decoded from the current state rather than
   // registered: the S_WR write data depends on ram_rdata, which only
   // arrives in that same cycle.
   always_comb begin
      state_d      = state_q;
      save_addr_d  = save_addr_q;
      save_data_d  = save_data_q;
      load_addr_d  = load_addr_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      save_ack_d   = 1'b0;
      ram_addr     = '0;
      ram_we       = 1'b0;
      ram_wdata    = '0;
`ifdef FRAME_CLEAR_EN
      clr_row_d    = clr_row_q;
`endif

      case (state_q)
         IDLE: begin
`ifdef FRAME_CLEAR_EN
            if (clear_start) begin
               state_d   = CLR;
               clr_row_d = '0;
            end else
`endif
            if (save_req) begin
               state_d     = S_RD;
               save_addr_d = save_addr;
               save_data_d = save_data;
            end else if (load_req) begin
               state_d     = L_RD;
               load_addr_d = load_addr;
            end
         end

         S_RD: begin
            ram_addr   = save_addr_q;
            save_ack_d = 1'b1;
            state_d    = S_WR;
         end

         S_WR: begin
            ram_addr = save_addr_q;
            if (save_in_range) begin
               ram_we    = 1'b1;
               ram_wdata = ram_rdata | save_data_q;
            end
            state_d = IDLE;
         end

         L_RD: begin
            ram_addr = load_addr_q;
            state_d  = L_CAP;
         end

         L_CAP: begin
            load_data_d  = load_in_range ? ram_rdata : '0;
            load_valid_d = 1'b1;
            state_d      = IDLE;
         end

`ifdef FRAME_CLEAR_EN
         CLR: begin
            ram_addr = clr_row_q;
            ram_we   = 1'b1;
            if (clr_last) begin
               state_d = IDLE;
            end else begin
               clr_row_d = clr_row_q + 9'd1;
            end
         end
`endif

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         save_addr_q  <= '0;
         save_data_q  <= '0;
         load_addr_q  <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         save_ack_q   <= 1'b0;
`ifdef FRAME_CLEAR_EN
         clr_row_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         save_addr_q  <= save_addr_d;
         save_data_q  <= save_data_d;
         load_addr_q  <= load_addr_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         save_ack_q   <= save_ack_d;
`ifdef FRAME_CLEAR_EN
         clr_row_q    <= clr_row_d;
`endif
      end
   end

   assign save_ack   = save_ack_q;
   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;

endmodule

// File: tb/tb_frame_ram_ctrl.sv
// tb_frame_ram_ctrl -- self-checking bench for frame_ram_ctrl. Hosts a
// behavioural single-port RAM (latency 1) and an independent frame model
// that is updated from the save/clear rules and compared against the DUT
// outputs and the RAM contents. Handles both FRAME_CLEAR_EN builds.
module tb_frame_ram_ctrl;

   localparam int unsigned ROWS  = 480;
   localparam int unsigned COLS  = 640;
   localparam int unsigned DEPTH = 512;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            save_req;
   logic [8:0]      save_addr;
   logic [COLS-1:0] save_data;
   logic            save_ack;
   logic            load_req;
   logic [8:0]      load_addr;
   logic            load_valid;
   logic [COLS-1:0] load_data;
   logic            clear_start;
   logic            clear_busy;
   logic [8:0]      ram_addr;
   logic            ram_we;
   logic [COLS-1:0] ram_wdata;
   logic [COLS-1:0] ram_rdata;

   logic            pl_en;
   logic [8:0]      pl_addr;
   logic [COLS-1:0] pl_data;

   logic [COLS-1:0] mem   [0:DEPTH-1];
   logic [COLS-1:0] model [0:DEPTH-1];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   frame_ram_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
      .CLOCK_50    (clk),
      .reset_n     (reset_n),
      .save_req    (save_req),
      .save_addr   (save_addr),
      .save_data   (save_data),
      .save_ack    (save_ack),
      .load_req    (load_req),
      .load_addr   (load_addr),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   // Single-port RAM, read latency 1; pl_* is a bench-only preload port.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   function automatic logic [COLS-1:0] rand_row();
      logic [COLS-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < COLS / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [COLS-1:0] sparse_row();
      return rand_row() & rand_row() & rand_row();
   endfunction

   function automatic logic in_range(input logic [8:0] a);
      return int'(a) < int'(ROWS);
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [COLS-1:0] obs, input logic [COLS-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_frame(input string tag);
      int bad;
      bad = 0;
      for (int r = 0; r < int'(DEPTH); r++) if (mem[r] !== model[r]) bad++;
      chki(tag, bad, 0);
   endtask

   // Starts at a negedge with the controller idle; ends at the T+3 negedge.
   task automatic do_save(input logic [8:0] a, input logic [COLS-1:0] d);
      save_req = 1'b1; save_addr = a; save_data = d;
      @(negedge clk);
      chk9("save_rd_addr", ram_addr, a);
      chk1("save_rd_we", ram_we, 1'b0);
      chk1("save_rd_ack", save_ack, 1'b0);
      save_req = 1'b0; save_addr = 9'($urandom_range(0, 511)); save_data = rand_row();
      @(negedge clk);
      chk1("save_wr_ack", save_ack, 1'b1);
      chk1("save_wr_we", ram_we, in_range(a));
      chk1("save_wr_lv", load_valid, 1'b0);
      if (in_range(a)) begin
         chkw("save_wr_data", ram_wdata, model[a] | d);
         model[a] = model[a] | d;
      end
      @(negedge clk);
      chk1("save_end_ack", save_ack, 1'b0);
      chk1("save_end_we", ram_we, 1'b0);
   endtask

   // Ends at the T+3 negedge (valid cycle) or, with hold, one cycle later.
   task automatic do_load(input logic [8:0] a, input logic hold);
      logic [COLS-1:0] e;
      e = in_range(a) ? model[a] : '0;
      load_req = 1'b1; load_addr = a;
      @(negedge clk);
      chk9("load_rd_addr", ram_addr, a);
      chk1("load_rd_we", ram_we, 1'b0);
      chk1("load_rd_lv", load_valid, 1'b0);
      load_req = 1'b0; load_addr = 9'($urandom_range(0, 511));
      @(negedge clk);
      chk1("load_cap_lv", load_valid, 1'b0);
      chk1("load_cap_we", ram_we, 1'b0);
      @(negedge clk);
      chk1("load_lv", load_valid, 1'b1);
      chk1("load_lv_ack", save_ack, 1'b0);
      chkw("load_data", load_data, e);
      if (hold) begin
         @(negedge clk);
         chk1("load_lv_drop", load_valid, 1'b0);
         chkw("load_hold", load_data, e);
      end
   endtask

   initial begin
      logic [COLS-1:0] d;
      int              bad;

      reset_n = 1'b0; save_req = 1'b0; save_addr = '0; save_data = '0;
      load_req = 1'b0; load_addr = '0; clear_start = 1'b0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;

      for (int r = 0; r < int'(DEPTH); r++) model[r] = rand_row();
      model[5] = '0; model[5][3:0] = 4'hF;
      model[7] = '0; model[7][15:0] = 16'hABCD;

      // Preload the RAM while the controller is held in reset.
      for (int r = 0; r < int'(DEPTH); r++) begin
         pl_en = 1'b1; pl_addr = 9'(r); pl_data = model[r];
         @(negedge clk);
      end
      pl_en = 1'b0;

      chk1("rst_we", ram_we, 1'b0);
      chk9("rst_addr", ram_addr, 9'd0);
      chkw("rst_wdata", ram_wdata, '0);
      chk1("rst_ack", save_ack, 1'b0);
      chk1("rst_lv", load_valid, 1'b0);
      chkw("rst_ldata", load_data, '0);
      chk1("rst_busy", clear_busy, 1'b0);

      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);

      // Directed save / load, including out-of-range rows.
      d = '0; d[10] = 1'b1;
      do_save(9'd5, d);
      do_load(9'd5, 1'b1);
      do_load(9'd7, 1'b1);
      do_save(9'd500, rand_row());
      do_load(9'd480, 1'b1);
      do_load(9'd511, 1'b0);
      do_load(9'd7, 1'b1);   // accepted in the same cycle as the previous valid

      // Save and load requested together: save first, then load.
      d = sparse_row();
      save_req = 1'b1; load_req = 1'b1; save_addr = 9'd20; load_addr = 9'd21; save_data = d;
      @(negedge clk);
      chk9("cont_s_addr", ram_addr, 9'd20);
      chk1("cont_s_lv", load_valid, 1'b0);
      save_req = 1'b0;
      @(negedge clk);
      chk1("cont_ack", save_ack, 1'b1);
      chk1("cont_we", ram_we, 1'b1);
      chkw("cont_wdata", ram_wdata, model[20] | d);
      model[20] = model[20] | d;
      @(negedge clk);
      chk1("cont_idle_ack", save_ack, 1'b0);
      chk1("cont_idle_we", ram_we, 1'b0);
      @(negedge clk);
      chk9("cont_l_addr", ram_addr, 9'd21);
      load_req = 1'b0;
      @(negedge clk);
      chk1("cont_l_cap", load_valid, 1'b0);
      @(negedge clk);
      chk1("cont_lv", load_valid, 1'b1);
      chkw("cont_ldata", load_data, model[21]);
      @(negedge clk);
      chk1("cont_lv_drop", load_valid, 1'b0);

      // Randomized mix of saves and loads across the full 9-bit address space.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 1) == 0) do_save(9'($urandom_range(0, 511)), sparse_row());
         else do_load(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      end
      chk_frame("frame_after_random");

      // Reset during the write cycle of a save aborts the write.
      d = ~model[40];
      save_req = 1'b1; save_addr = 9'd40; save_data = d;
      @(negedge clk);
      save_req = 1'b0;
      @(negedge clk);
      chk1("rsave_we_before", ram_we, 1'b1);
      reset_n = 1'b0;
      #1;
      chk1("rsave_we", ram_we, 1'b0);
      chk1("rsave_ack", save_ack, 1'b0);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      chk_frame("frame_after_save_abort");

`ifdef FRAME_CLEAR_EN
      // Reset partway through a clear leaves the untouched rows intact.
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      repeat (100) @(negedge clk);
      chk9("rclr_addr", ram_addr, 9'd100);
      chk1("rclr_busy_before", clear_busy, 1'b1);
      reset_n = 1'b0;
      #1;
      chk1("rclr_we", ram_we, 1'b0);
      chk1("rclr_busy", clear_busy, 1'b0);
      chk9("rclr_raddr", ram_addr, 9'd0);
      for (int r = 0; r < 100; r++) model[r] = '0;
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      chk_frame("frame_after_clear_abort");

      // Full clear with a save pending: clear runs first, then the save.
      d = sparse_row();
      clear_start = 1'b1; save_req = 1'b1; save_addr = 9'd33; save_data = d;
      @(negedge clk);
      clear_start = 1'b0;
      bad = 0;
      for (int i = 0; i < int'(ROWS); i++) begin
         if (!(clear_busy === 1'b1 && ram_we === 1'b1 && ram_addr === 9'(i) &&
               ram_wdata === '0 && save_ack === 1'b0)) bad++;
         @(negedge clk);
      end
      chki("clr_sequence", bad, 0);
      for (int r = 0; r < int'(ROWS); r++) model[r] = '0;
      chk1("clr_done_busy", clear_busy, 1'b0);
      chk1("clr_done_we", ram_we, 1'b0);
      @(negedge clk);
      chk9("clr_save_addr", ram_addr, 9'd33);
      save_req = 1'b0;
      @(negedge clk);
      chk1("clr_save_ack", save_ack, 1'b1);
      chkw("clr_save_wdata", ram_wdata, d);
      model[33] = d;
      @(negedge clk);
      chk1("clr_save_ack_drop", save_ack, 1'b0);
`else
      // Without the clear engine clear_start is ignored and the save proceeds.
      d = sparse_row();
      clear_start = 1'b1; save_req = 1'b1; save_addr = 9'd33; save_data = d;
      @(negedge clk);
      chk1("noclr_busy", clear_busy, 1'b0);
      chk9("noclr_save_addr", ram_addr, 9'd33);
      save_req = 1'b0;
      @(negedge clk);
      chk1("noclr_save_ack", save_ack, 1'b1);
      chkw("noclr_save_wdata", ram_wdata, model[33] | d);
      model[33] = model[33] | d;
      @(negedge clk);
      bad = 0;
      repeat (20) begin
         if (clear_busy !== 1'b0 || ram_we !== 1'b0) bad++;
         @(negedge clk);
      end
      chki("noclr_idle", bad, 0);
      clear_start = 1'b0;
`endif
      chk_frame("frame_final");
      do_load(9'd33, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
